// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks in the last cycle of every bit while enabled.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 218
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick_o = en_i && (cnt == LAST);

    // Clear has priority so a new frame always starts on a full-length bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, LSB-first 8N1 or 8E1/8O1 serial output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 218,
    parameter int PARITY       = PAR_NONE
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [UART_DATA_W-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic [2:0]             state_o
);

    // Handshake: a byte transfers on a rising clk_i edge where valid_i && ready_o;
    // the producer may change data_i freely at any other time.

    localparam logic [2:0] S_IDLE  = uart_pkg::IDLE;
    localparam logic [2:0] S_START = uart_pkg::START;
    localparam logic [2:0] S_DATA  = uart_pkg::DATA;
    localparam logic [2:0] S_PAR   = uart_pkg::PARITY;
    localparam logic [2:0] S_STOP  = uart_pkg::STOP;

    logic [2:0]             state;
    logic [UART_DATA_W-1:0] shreg;
    logic [2:0]             bit_idx;
    logic                   par_bit;
    logic                   tick;
    logic                   cnt_en;
    logic                   accept;
    logic                   tx_next;

    assign cnt_en  = (state != S_IDLE);
    assign ready_o = (state == S_IDLE) || ((state == S_STOP) && tick);
    assign busy_o  = (state != S_IDLE);
    assign accept  = valid_i && ready_o;
    assign state_o = state;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .clr_i (accept),
        .en_i  (cnt_en),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            par_bit <= 1'b0;
        end else if (accept) begin
            state   <= S_START;
            shreg   <= data_i;
            bit_idx <= '0;
            par_bit <= (PARITY == PAR_ODD) ? ~(^data_i) : ^data_i;
        end else if (tick) begin
            case (state)
                S_START: state <= S_DATA;
                S_DATA: begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
                end
                S_PAR:   state <= S_STOP;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The line level is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        tx_next = 1'b1;
        case (state)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shreg[0];
            S_PAR:   tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) tx_o <= 1'b1;
        else         tx_o <= tx_next;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/even/odd parity) at 4 clocks per bit.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic       clk;
  logic       rstn;
  logic [7:0] data;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] st0, st1, st2;

  int n_vec;
  int n_err;
  int acc_cnt [3];
  logic [0:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_NONE)) dut_none (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .valid_i(valid[0]),
    .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .state_o(st0)
  );
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN)) dut_even (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .valid_i(valid[1]),
    .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .state_o(st1)
  );
  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(PAR_ODD)) dut_odd (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .valid_i(valid[2]),
    .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]), .state_o(st2)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (valid[i] && ready[i]) acc_cnt[i]++;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_ready(input int inst, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ready[inst]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Send one byte and compare every line cycle against the hand-built frame.
  // pulse_at >= 0 injects an ignored valid with data 0; abort_at >= 0 asserts reset there.
  task automatic run_frame(input int inst, input logic [7:0] d, input logic [10:0] frame,
                           input int nbits, input int pulse_at, input int abort_at);
    bit ok;
    int base;
    int n;
    logic [0:0] e;
    n = nbits * CPB;
    exp_q.delete();
    for (int b = 0; b < nbits; b++)
      for (int j = 0; j < CPB; j++) exp_q.push_back(frame[b]);
    wait_ready(inst, ok);
    if (!ok) return;
    base = acc_cnt[inst];
    data = d;
    valid[inst] = 1'b1;
    @(posedge clk);
    #1;
    valid[inst] = 1'b0;
    data = $urandom_range(0, 255);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("tx%0d_c%0d", inst, c), 32'(tx[inst]), 32'(e));
      if (c == 0) check("busy_start", 32'(busy[inst]), 32'd1);
      if (c == n - 3) check("ready_low_late", 32'(ready[inst]), 32'd0);
      if (c == n - 2) check("ready_last_stop", 32'(ready[inst]), 32'd1);
      if (c == pulse_at) begin
        data = 8'h00;
        valid[inst] = 1'b1;
      end
      if (c == pulse_at + 1) valid[inst] = 1'b0;
      if (c == abort_at) begin
        rstn = 1'b0;
        #1;
        check("abort_tx", 32'(tx[inst]), 32'd1);
        check("abort_busy", 32'(busy[inst]), 32'd0);
        check("abort_ready", 32'(ready[inst]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
    end
    @(posedge clk);
    #1;
    check("idle_tx", 32'(tx[inst]), 32'd1);
    check("idle_busy", 32'(busy[inst]), 32'd0);
    check("accepts", 32'(acc_cnt[inst] - base), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check("no_extra_frame", 32'({tx[inst], busy[inst]}), 32'b10);
    end
  endtask

  task automatic run_back_to_back();
    bit ok;
    int base;
    logic [9:0] f1;
    logic [9:0] f2;
    f1 = 10'b1_01010101_0;  // 8'h55
    f2 = 10'b1_11111111_0;  // 8'hFF
    wait_ready(0, ok);
    if (!ok) return;
    base = acc_cnt[0];
    data = 8'h55;
    valid[0] = 1'b1;
    @(posedge clk);
    #1;
    data = 8'hFF;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (c < 40) check($sformatf("b2b_f1_c%0d", c), 32'(tx[0]), 32'(f1[c / CPB]));
      else        check($sformatf("b2b_f2_c%0d", c), 32'(tx[0]), 32'(f2[(c - 40) / CPB]));
      if (c == 39) valid[0] = 1'b0;
      if (c == 39) check("b2b_busy_gap", 32'(busy[0]), 32'd1);
    end
    check("b2b_accepts", 32'(acc_cnt[0] - base), 32'd2);
    @(posedge clk);
    #1;
    check("b2b_idle", 32'({tx[0], busy[0], ready[0]}), 32'b101);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
    rstn  = 1'b0;
    valid = 3'b000;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'b111);
    check("rst_busy", 32'(busy), 32'b000);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_tx", 32'(tx), 32'b111);
      check("post_rst_ready", 32'(ready), 32'b111);
      check("post_rst_busy", 32'(busy), 32'b000);
    end
    check("post_rst_state", 32'(st0), 32'(IDLE));

    // 8'hA5, no parity: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 8'hA5, 11'b0_1_10100101_0, 10, -1, -1);
    // 8'h07 even parity -> 1, odd parity -> 0
    run_frame(1, 8'h07, 11'b1_1_00000111_0, 11, -1, -1);
    run_frame(2, 8'h07, 11'b1_0_00000111_0, 11, -1, -1);
    run_back_to_back();
    // ignored mid-frame valid with data 8'h00
    run_frame(0, 8'h3C, 11'b0_1_00111100_0, 10, 10, -1);
    // reset during data bit 3 (line cycles 16..19), then a fresh byte
    run_frame(0, 8'hC3, 11'b0_1_11000011_0, 10, -1, 17);
    check("after_abort_busy", 32'(busy), 32'b000);
    run_frame(0, 8'h96, 11'b0_1_10010110_0, 10, -1, -1);
    run_frame(1, 8'h96, 11'b1_0_10010110_0, 11, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
